mem_arbiter: RTL

- Shares the single 128-bit line-granular memory port between the instruction cache and the data cache.
- Each cache drives its own mem_read/mem_write/mem_addr/mem_wdata, held until ready.
- The arbiter grants one requester at a time, latches its request, drives the shared memory port and returns mem_ready/mem_rdata to the owner only.
- Sits between the two cache instances and the memory model inside the CPU top.

---
 rtl/mem_arbiter_pkg.sv | 23 ++
 rtl/mem_arbiter_if.sv | 17 +
 rtl/mem_arbiter_rr_arb2.sv | 33 +++
 rtl/mem_arbiter.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the I/D-cache memory-port arbiter.
package mem_arb_pkg;

    localparam int unsigned ADDR_W_DEF = 28;
    localparam int unsigned DATA_W_DEF = 128;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY_I = 2'd1,
        ST_BUSY_D = 2'd2
    } arb_state_e;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } arb_op_e;

    // A requester raising both strobes is a protocol violation; it is serviced as a write.
    function automatic logic is_dual_op(input logic rd, input logic wr);
        return rd & wr;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Line-granular memory request port shared by caches (master side) and memory (slave side).
interface mem_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
);
    logic              read;
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              ready;

    modport master (output read, write, addr, wdata, input rdata, ready);
    modport slave  (input read, write, addr, wdata, output rdata, ready);
endinterface

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-input round-robin grant; the pointer moves only when the caller takes a grant.
module rr_arb2
    import mem_arb_pkg::*;
#(
    parameter int unsigned FIRST_PRIO_D = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_req_i,
    input  logic i_req_d,
    input  logic i_take,
    output logic o_gnt_i,
    output logic o_gnt_d
);
    logic r_prio_d;

    // Grant follows the pointer only under contention.
    always_comb begin
        o_gnt_d = i_req_d & (~i_req_i | r_prio_d);
        o_gnt_i = i_req_i & ~o_gnt_d;
    end

    // Pointer favours whichever side lost the last taken grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prio_d <= (FIRST_PRIO_D != 32'd0);
        end else if (i_take & (o_gnt_i | o_gnt_d)) begin
            r_prio_d <= o_gnt_i;
        end else begin
            r_prio_d <= r_prio_d;
        end
    end
endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single memory line port between the I-cache and the D-cache.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W       = ADDR_W_DEF,
    parameter int unsigned DATA_W       = DATA_W_DEF,
    parameter int unsigned TIMEOUT      = 1023,
    parameter int unsigned FIRST_PRIO_D = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    mem_arbiter_if.slave    icache,
    mem_arbiter_if.slave    dcache,
    mem_arbiter_if.master   mem,
    output logic            arb_err
);
    localparam int unsigned CNT_W = (TIMEOUT > 32'd0) ? $clog2(TIMEOUT + 32'd1) : 1;

    arb_state_e        r_state, w_next;
    arb_op_e           r_op;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [CNT_W-1:0]  r_tcnt;
    logic              r_err;

    logic w_req_i, w_req_d, w_gnt_i, w_gnt_d, w_take;
    logic w_load_i, w_load_d, w_busy, w_done_i, w_done_d, w_tmo_hit;

    assign w_req_i  = icache.read | icache.write;
    assign w_req_d  = dcache.read | dcache.write;
    assign w_busy   = (r_state != ST_IDLE);
    assign w_done_i = (r_state == ST_BUSY_I) & mem.ready;
    assign w_done_d = (r_state == ST_BUSY_D) & mem.ready;

    rr_arb2 #(.FIRST_PRIO_D(FIRST_PRIO_D)) u_rr (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_req_i (w_req_i),
        .i_req_d (w_req_d),
        .i_take  (w_take),
        .o_gnt_i (w_gnt_i),
        .o_gnt_d (w_gnt_d)
    );

    // Next state; a completing owner hands straight to a pending peer without arbitration.
    always_comb begin
        w_next   = r_state;
        w_load_i = 1'b0;
        w_load_d = 1'b0;
        w_take   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_take = 1'b1;
                if (w_gnt_d) begin
                    w_next   = ST_BUSY_D;
                    w_load_d = 1'b1;
                end else if (w_gnt_i) begin
                    w_next   = ST_BUSY_I;
                    w_load_i = 1'b1;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_BUSY_I: begin
                if (mem.ready & w_req_d) begin
                    w_next   = ST_BUSY_D;
                    w_load_d = 1'b1;
                end else if (mem.ready) begin
                    w_next = ST_IDLE;
                end else begin
                    w_next = ST_BUSY_I;
                end
            end
            ST_BUSY_D: begin
                if (mem.ready & w_req_i) begin
                    w_next   = ST_BUSY_I;
                    w_load_i = 1'b1;
                end else if (mem.ready) begin
                    w_next = ST_IDLE;
                end else begin
                    w_next = ST_BUSY_D;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Request latch; later changes on the cache side are ignored until the next grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_op    <= OP_RD;
        end else if (w_load_i) begin
            r_addr  <= icache.addr;
            r_wdata <= icache.wdata;
            r_op    <= icache.write ? OP_WR : OP_RD;
        end else if (w_load_d) begin
            r_addr  <= dcache.addr;
            r_wdata <= dcache.wdata;
            r_op    <= dcache.write ? OP_WR : OP_RD;
        end else begin
            r_addr  <= r_addr;
            r_wdata <= r_wdata;
            r_op    <= r_op;
        end
    end

    assign w_tmo_hit = (TIMEOUT != 32'd0) & w_busy & ~mem.ready &
                       ((32'(r_tcnt) + 32'd1) >= TIMEOUT);

    // Busy-cycle counter and sticky error flag; the arbiter keeps waiting after a timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tcnt <= '0;
            r_err  <= 1'b0;
        end else begin
            if (w_load_i | w_load_d) begin
                r_tcnt <= '0;
            end else if (w_busy & ~mem.ready & (r_tcnt != {CNT_W{1'b1}})) begin
                r_tcnt <= r_tcnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                r_tcnt <= r_tcnt;
            end
            if ((w_load_i & is_dual_op(icache.read, icache.write)) |
                (w_load_d & is_dual_op(dcache.read, dcache.write)) | w_tmo_hit) begin
                r_err <= 1'b1;
            end else begin
                r_err <= r_err;
            end
        end
    end

    assign mem.read     = w_busy & (r_op == OP_RD) & ~mem.ready;
    assign mem.write    = w_busy & (r_op == OP_WR) & ~mem.ready;
    assign mem.addr     = w_busy ? r_addr : '0;
    assign mem.wdata    = w_busy ? r_wdata : '0;
    assign icache.ready = w_done_i;
    assign dcache.ready = w_done_d;
    assign icache.rdata = (w_done_i & (r_op == OP_RD)) ? mem.rdata : '0;
    assign dcache.rdata = (w_done_d & (r_op == OP_RD)) ? mem.rdata : '0;
    assign arb_err      = r_err;
endmodule
